// File: rtl/count9999_disp.sv
// count9999_disp
//   Downstream stage of the Count9999 clock divider. The divider's clk_hz and
//   clk_khz outputs arrive as plain data and are synchronized and edge-detected
//   in the clki domain. A clk_hz rise is one count tick for a 4-digit BCD
//   up/down counter (0000-9999). A clk_khz rise advances the scanned digit of a
//   common-anode 4-digit 7-segment display.
//
// Parameters
//   SYNC_STAGES : synchronizer depth for clk_hz / clk_khz (legal 2..3)
//
// Ports
//   clki    : system clock (only clock)
//   rst     : asynchronous active-high reset
//   clk_hz  : count pulse source, one tick per rising edge
//   clk_khz : scan source, one digit advance per rising edge
//   en      : count enable (sampled in the tick cycle)
//   up      : 1 = count up, 0 = count down (sampled in the tick cycle)
//   clr     : synchronous clear to 0000, highest priority
//   bcd     : registered count, bcd[15:12] = thousands
//   tc      : one-cycle pulse on wrap (9999->0000 up, 0000->9999 down)
//   an      : active-low one-hot digit enables, an[0] = ones digit
//   seg     : active-low segments {g,f,e,d,c,b,a}
//   dp      : decimal point, constant 1 (off)
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, zero digits above the most
//   significant nonzero digit are blanked. The ones digit is never blanked.

module count9999_disp #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clki,
  input  logic        rst,
  input  logic        clk_hz,
  input  logic        clk_khz,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] bcd,
  output logic        tc,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [SYNC_STAGES-1:0] hz_sync;
  logic [SYNC_STAGES-1:0] khz_sync;
  logic                   hz_prev;
  logic                   khz_prev;
  logic                   hz_tick;
  logic                   khz_tick;

  logic [1:0]  idx;
  logic [15:0] bcd_inc;
  logic [15:0] bcd_dec;
  logic        inc_c;
  logic        dec_b;
  logic [3:0]  digit;
  logic        blank;

  // Synchronizers plus one "previous" flop per source. Because all of them
  // reset to 0, an input already high at reset release reads as one rise.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      hz_sync  <= '0;
      khz_sync <= '0;
      hz_prev  <= 1'b0;
      khz_prev <= 1'b0;
    end else begin
      hz_sync  <= {hz_sync[SYNC_STAGES-2:0], clk_hz};
      khz_sync <= {khz_sync[SYNC_STAGES-2:0], clk_khz};
      hz_prev  <= hz_sync[SYNC_STAGES-1];
      khz_prev <= khz_sync[SYNC_STAGES-1];
    end
  end

  assign hz_tick  = hz_sync[SYNC_STAGES-1] & ~hz_prev;
  assign khz_tick = khz_sync[SYNC_STAGES-1] & ~khz_prev;

  // Ripple BCD increment: 9 -> 0 with carry. Carry out of the thousands digit
  // is dropped, so 9999 naturally becomes 0000.
  always_comb begin
    bcd_inc = '0;
    inc_c   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!inc_c) begin
        bcd_inc[4*i +: 4] = bcd[4*i +: 4];
      end else if (bcd[4*i +: 4] == 4'd9) begin
        bcd_inc[4*i +: 4] = 4'd0;
      end else begin
        bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
        inc_c             = 1'b0;
      end
    end
  end

  // Ripple BCD decrement: 0 -> 9 with borrow; 0000 becomes 9999.
  always_comb begin
    bcd_dec = '0;
    dec_b   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!dec_b) begin
        bcd_dec[4*i +: 4] = bcd[4*i +: 4];
      end else if (bcd[4*i +: 4] == 4'd0) begin
        bcd_dec[4*i +: 4] = 4'd9;
      end else begin
        bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
        dec_b             = 1'b0;
      end
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      bcd <= '0;
      tc  <= 1'b0;
    end else if (clr) begin
      bcd <= '0;
      tc  <= 1'b0;
    end else if (hz_tick && en) begin
      if (up) begin
        bcd <= bcd_inc;
        tc  <= (bcd == 16'h9999);
      end else begin
        bcd <= bcd_dec;
        tc  <= (bcd == 16'h0000);
      end
    end else begin
      tc <= 1'b0;
    end
  end

  // Scan index is independent of en and clr.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (khz_tick) begin
      idx <= idx + 2'd1;
    end
  end

  always_comb begin
    an    = ~(4'b0001 << idx);
    digit = bcd[{idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant digit
    // are zero; idx 0 (ones) is always shown.
    blank = (idx != 2'd0) && ((bcd >> {idx, 2'b00}) == 16'h0000);
`else
    blank = 1'b0;
`endif
    unique case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (blank) begin
      seg = 7'b1111111;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_count9999_disp.sv
// Testbench for count9999_disp. A reference model keeps the count as a plain
// integer 0..9999 and derives the expected BCD, wrap pulse, digit enables and
// segments from it by arithmetic. Input history arrays give the tick timing:
// a rise sampled at edge N acts at edge N+SYNC_STAGES.

module tb_count9999_disp;

  localparam int unsigned S = 2;

  localparam logic [6:0] SEGT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam int PW [4] = '{1, 10, 100, 1000};
  localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clki = 1'b0;
  logic        rst;
  logic        clk_hz, clk_khz, en, up, clr;
  logic [15:0] bcd;
  logic        tc;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int   m_cnt;
  int   m_idx;
  logic m_tc;
  logic hzh  [0:5];
  logic khzh [0:5];

  count9999_disp #(.SYNC_STAGES(S)) dut (
    .clki    (clki),
    .rst     (rst),
    .clk_hz  (clk_hz),
    .clk_khz (clk_khz),
    .en      (en),
    .up      (up),
    .clr     (clr),
    .bcd     (bcd),
    .tc      (tc),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clki = ~clki;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    return 16'(r);
  endfunction

  function automatic logic [6:0] exp_seg(input int cnt, input int id);
    int d;
    d = (cnt / PW[id]) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (id > 0 && cnt < PW[id]) return 7'b1111111;
`endif
    return SEGT[d];
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_tc  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      hzh[k]  = 1'b0;
      khzh[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    check("bcd", 32'(bcd), 32'(to_bcd(m_cnt)));
    check("tc",  32'(tc),  32'(m_tc));
    check("an",  32'(an),  32'(AN_SEQ[m_idx]));
    check("seg", 32'(seg), 32'(exp_seg(m_cnt, m_idx)));
    check("dp",  32'(dp),  32'd1);
  endtask

  // Called at a negedge: drive inputs, take one rising edge, advance the
  // model, then compare at the following negedge.
  task automatic cycle(input logic hz, input logic khz, input logic e,
                       input logic u, input logic c);
    clk_hz  = hz;
    clk_khz = khz;
    en      = e;
    up      = u;
    clr     = c;
    @(posedge clki);
    for (int k = 5; k > 0; k--) begin
      hzh[k]  = hzh[k-1];
      khzh[k] = khzh[k-1];
    end
    hzh[0]  = hz;
    khzh[0] = khz;
    m_tc = 1'b0;
    if (c) begin
      m_cnt = 0;
    end else if (hzh[S] && !hzh[S+1] && e) begin
      if (u) begin
        if (m_cnt == 9999) begin m_cnt = 0; m_tc = 1'b1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin m_cnt = 9999; m_tc = 1'b1; end
        else m_cnt = m_cnt - 1;
      end
    end
    if (khzh[S] && !khzh[S+1]) m_idx = (m_idx + 1) % 4;
    @(negedge clki);
    check_all();
  endtask

  task automatic pulses(input int n, input logic e, input logic u);
    for (int p = 0; p < n; p++) begin
      cycle(1'b1, 1'b0, e, u, 1'b0);
      cycle(1'b0, 1'b0, e, u, 1'b0);
    end
  endtask

  task automatic settle(input int n);
    for (int p = 0; p < n; p++) cycle(1'b0, 1'b0, en, up, 1'b0);
  endtask

  int tc_seen;

  initial begin
    rst = 1'b1; clk_hz = 1'b0; clk_khz = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0;
    model_reset();
    @(posedge clki); @(negedge clki);
    check_all();
    check("rst_an", 32'(an), 32'(4'b1110));
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    rst = 1'b0;

    // 12 up ticks
    pulses(12, 1'b1, 1'b1);
    settle(3);
    check("cnt12", 32'(bcd), 32'h0012);

    // up to 9998, then wrap
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    pulses(9998, 1'b1, 1'b1);
    settle(3);
    check("pre9998", 32'(bcd), 32'h9998);
    pulses(1, 1'b1, 1'b1);
    settle(3);
    check("cnt9999", 32'(bcd), 32'h9999);
    tc_seen = 0;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    if (tc) tc_seen++;
    for (int p = 0; p < 5; p++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (tc) tc_seen++;
    end
    check("wrap_up", 32'(bcd), 32'h0000);
    check("wrap_tc_cycles", 32'(tc_seen), 32'd1);

    // down from 0000
    tc_seen = 0;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (tc) tc_seen++;
    end
    check("wrap_dn", 32'(bcd), 32'h9999);
    check("wrap_dn_tc_cycles", 32'(tc_seen), 32'd1);
    pulses(10, 1'b1, 1'b0);
    settle(3);
    check("cnt9989", 32'(bcd), 32'h9989);

    // clear coincident with a tick at 0057
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    pulses(57, 1'b1, 1'b1);
    settle(3);
    check("cnt57", 32'(bcd), 32'h0057);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_bcd", 32'(bcd), 32'h0000);
    check("clr_tc", 32'(tc), 32'd0);
    settle(3);
    check("clr_hold", 32'(bcd), 32'h0000);
    pulses(5, 1'b0, 1'b0);
    settle(3);
    check("en0_hold", 32'(bcd), 32'h0000);

    // scanning at 0305
    pulses(305, 1'b1, 1'b1);
    settle(3);
    check("cnt305", 32'(bcd), 32'h0305);
    check("scan0_an", 32'(an), 32'(4'b1110));
    check("scan0_seg", 32'(seg), 32'(7'b0010010));
    for (int p = 0; p < 8; p++) begin
      logic [6:0] want;
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("scan_an", 32'(an), 32'(AN_SEQ[(p + 1) % 4]));
      case ((p + 1) % 4)
        0: want = 7'b0010010;
        1: want = 7'b1000000;
        2: want = 7'b0110000;
`ifdef LEADING_ZERO_BLANK_EN
        default: want = 7'b1111111;
`else
        default: want = 7'b1000000;
`endif
      endcase
      check("scan_seg", 32'(seg), 32'(want));
    end

    // randomized phase
    for (int p = 0; p < 3000; p++) begin
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
            1'($urandom), ($urandom_range(0, 15) == 0));
    end

    // reset while clk_hz is held high, with a rise pending
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    pulses(3, 1'b1, 1'b1);
    settle(3);
    check("pre_rst", 32'(bcd), 32'h0003);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_bcd", 32'(bcd), 32'h0000);
    check("arst_tc",  32'(tc), 32'd0);
    check("arst_an",  32'(an), 32'(4'b1110));
    check("arst_seg", 32'(seg), 32'(7'b1000000));
    @(posedge clki); @(posedge clki); @(negedge clki);
    rst = 1'b0;
    for (int p = 0; p < 6; p++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("post_rst", 32'(bcd), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count9999_disp.md
# count9999_disp

- Downstream stage of the clock divider in the Count9999 design.
- Consumes the divider's slow `clk_hz` and scan-rate `clk_khz` outputs as data signals and edge-detects them in the `clki` domain.
- Maintains a 4-digit BCD counter with range 0000–9999, supporting up/down counting, enable and clear.
- Time-multiplexes the digits onto a common-anode 4-digit 7-segment display.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `clk_hz` and `clk_khz`; legal values 2–3.

Ports:
- `clki`: input, 1 bit. System clock; the only clock.
- `rst`: input, 1 bit. Reset, asynchronous, active-high.
- `clk_hz`: input, 1 bit. Count pulse source from the divider. Each rising edge is one count tick.
- `clk_khz`: input, 1 bit. Scan source from the divider. Each rising edge advances the scanned digit.
- `en`: input, 1 bit. Count enable. When 0, count ticks are ignored.
- `up`: input, 1 bit. Direction: 1 counts up, 0 counts down.
- `clr`: input, 1 bit. Synchronous clear to 0000.
- `bcd`: output, 16 bits. Registered count, four BCD digits; `bcd[15:12]` is thousands.
- `tc`: output, 1 bit. One-cycle pulse when the count wraps.
- `an`: output, 4 bits. Digit enables, active-low one-hot; `an[0]` is the ones digit.
- `seg`: output, 7 bits. Segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`: output, 1 bit. Decimal point, constant 1 (off).

## Operation
Tick generation:
- Each of `clk_hz` and `clk_khz` passes through a `SYNC_STAGES`-deep flop chain, followed by one "previous" flop.
- tick = last sync stage AND NOT previous.

Counting (priority order, evaluated at each `clki` edge):
1. `clr` = 1: all digits go to 0, `tc` = 0. This applies regardless of `en` or tick.
2. Count tick AND `en` AND `up`:
   - Increment with BCD carry: a digit at 9 goes to 0 and carries into the next digit.
   - 9999 wraps to 0000 and `tc` = 1 for one cycle.
3. Count tick AND `en` AND NOT `up`:
   - Decrement with BCD borrow: a digit at 0 goes to 9 and borrows from the next digit.
   - 0000 wraps to 9999 and `tc` = 1 for one cycle.
4. Otherwise: hold, `tc` = 0.

Digit invariants:
- Every digit is always in 0–9; no code A–F is ever produced.
- `up` and `en` are sampled only in the tick cycle.

Scanning:
- A 2-bit index `idx` increments modulo 4 on each scan tick.
- Scanning is independent of `en` and `clr`.
- `an` = ~(4'b0001 << idx).
- `seg` is the decoded digit `bcd[4*idx+3 : 4*idx]`. Decode table: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- `an` and `seg` are combinational from the registered `idx` and `bcd`.

## Timing
Reset values:
- `bcd` = 16'h0000, `tc` = 0, `idx` = 0.
- Therefore `an` = 4'b1110, `seg` = 7'b1000000, `dp` = 1.
- All synchronizer and previous flops reset to 0.

Latency, with `SYNC_STAGES` = 2:
- The `clk_hz` rise is first captured at edge N.
- The tick is high for exactly one cycle, between N+1 and N+2.
- `bcd` and `tc` update at edge N+2.
- Each extra stage adds one cycle.
- `clk_khz` follows the same latency for `idx`.

Edge-detect rules:
- Exactly one tick per input rising edge.
- Falling edges and held-high levels produce no tick.
- An input already high at reset release counts as one rising edge.

Boundary conditions:
- Count tick coincident with `clr`: the clear wins; no count, no `tc`.
- Count tick and scan tick in the same cycle: both act; `seg` reflects the new `bcd` and `idx` in the following cycle.
- `rst` asserted mid-count: immediate asynchronous return to the reset values, including the sync flops; any pending tick is lost.

## Configuration
Macro `LEADING_ZERO_BLANK_EN`:
- Defined:
  - Leading-zero digits are blanked (`seg` = 7'b1111111). A leading zero is any zero digit more significant than the most significant nonzero digit.
  - `an` still scans normally.
  - The ones digit is never blanked, so 0000 shows "0" and 0042 shows "42".
- Undefined: all four digits are always displayed, e.g. 0042 shows "0042".
- `bcd` is unaffected either way.

## Test plan
- Reset, then 12 `clk_hz` pulses with `en` = 1, `up` = 1:
  - `bcd` = 16'h0012.
  - Each increment lands exactly 2 cycles after the sampled rise.
- Preload to 9998 via up-counting, then 2 ticks:
  - `bcd` goes 9999 then 0000.
  - `tc` is high for exactly one cycle on the wrap.
- From 0000 with `up` = 0, 1 tick:
  - `bcd` = 16'h9999 and `tc` pulses.
  - With a further 10 ticks: `bcd` = 16'h9989.
- Assert `clr` in the same cycle as a count tick at `bcd` = 0057:
  - `bcd` = 0000, `tc` = 0.
  - With `en` = 0 and 5 ticks: `bcd` unchanged.
- 8 `clk_khz` pulses:
  - `an` sequence is 1110, 1101, 1011, 0111, repeated.
  - With `bcd` = 0305, `seg` per digit = 0010010, 1000000, 0110000, 1000000.
  - With `LEADING_ZERO_BLANK_EN` defined, the thousands digit instead shows 1111111.
- Assert `rst` while `clk_hz` is held high mid-count:
  - All outputs return to their reset values immediately.
  - After release, exactly one tick occurs: `bcd` = 0001.
